// File: rtl/zigbee_router_pkg.sv
// zigbee_router_pkg: shared FSM state type, counter width and guard-width helper for the ZigBee I/O router.
package zigbee_router_pkg;
    typedef enum logic [1:0] {ACTIVE, DRAIN, APPLY} router_state_e;
    localparam int SWITCH_CNT_W = 16;
    function automatic int guard_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/zigbee_router_guard_fsm.sv
// zigbee_router_guard_fsm: guarded mode-switch sequencer (drain, apply), sticky error flag, switch counter.
// Define ZIGBEE_IO_ROUTER_SWITCH_CNT_EN to build the saturating completed-switch counter.
module zigbee_router_guard_fsm
    import zigbee_router_pkg::*;
#(
    parameter int N_MODES      = 4,
    parameter int GUARD_CYCLES = 4,
    parameter int RESET_MODE   = 0,
    parameter int MODE_W       = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [MODE_W-1:0]       mode_i,
    input  logic                    mode_valid_i,
    output logic                    mode_ready_o,
    output logic [MODE_W-1:0]       mode_o,
    output logic                    mode_err_o,
    output router_state_e           state_o,
    output logic [SWITCH_CNT_W-1:0] switch_cnt_o
);
    localparam int GW = guard_w(GUARD_CYCLES);
    router_state_e state_q, state_d;
    logic [GW-1:0] cnt_q, cnt_d;
    logic [MODE_W-1:0] mode_q, mode_d, pend_q, pend_d;
    logic err_q, err_d;
    logic req_bad, req_new;
    assign req_bad = mode_valid_i && (int'(mode_i) >= N_MODES);
    assign req_new = mode_valid_i && !req_bad && (mode_i != mode_q);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        err_d   = err_q | ((state_q == ACTIVE) && req_bad);
        if (state_q == ACTIVE && req_new) begin
            state_d = DRAIN;
            cnt_d   = GW'(GUARD_CYCLES - 1);
            pend_d  = mode_i;
        end
        if (state_q == DRAIN) begin
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - GW'(1);
            state_d = (cnt_q == '0) ? APPLY : DRAIN;
        end
        if (state_q == APPLY) begin
            mode_d  = pend_q;
            state_d = ACTIVE;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
            mode_q  <= MODE_W'(RESET_MODE);
            pend_q  <= MODE_W'(RESET_MODE);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end
    assign state_o      = state_q;
    assign mode_o       = mode_q;
    assign mode_err_o   = err_q;
    assign mode_ready_o = (state_q == ACTIVE);
`ifdef ZIGBEE_IO_ROUTER_SWITCH_CNT_EN
    logic [SWITCH_CNT_W-1:0] sw_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) sw_q <= '0;
        else if (state_q == APPLY && sw_q != '1) sw_q <= sw_q + SWITCH_CNT_W'(1);
    end
    assign switch_cnt_o = sw_q;
`else
    assign switch_cnt_o = '0;
`endif
endmodule

// File: rtl/zigbee_io_router.sv
// zigbee_io_router: routes the shared pad bus to one of N_MODES block groups with guarded mode switching.
// Optional ZIGBEE_IO_ROUTER_SWITCH_CNT_EN enables switch_cnt_o (otherwise tied to zero).
module zigbee_io_router
    import zigbee_router_pkg::*;
#(
    parameter int N_MODES      = 4,
    parameter int IN_W         = 22,
    parameter int OUT_W        = 18,
    parameter int GUARD_CYCLES = 4,
    parameter int RESET_MODE   = 0,
    localparam int MODE_W      = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [MODE_W-1:0]          mode_i,
    input  logic                       mode_valid_i,
    output logic                       mode_ready_o,
    output logic [MODE_W-1:0]          mode_o,
    output logic                       mode_err_o,
    input  logic [IN_W-1:0]            mux_i,
    output logic [OUT_W-1:0]           mux_o,
    output logic [N_MODES*IN_W-1:0]    blk_in_o,
    input  logic [N_MODES*OUT_W-1:0]   blk_out_i,
    output logic [N_MODES-1:0]         blk_en_o,
    output logic [SWITCH_CNT_W-1:0]    switch_cnt_o
);
    router_state_e state;
    logic active;
    logic [OUT_W-1:0] mux_q, mux_d;
    zigbee_router_guard_fsm #(
        .N_MODES(N_MODES), .GUARD_CYCLES(GUARD_CYCLES), .RESET_MODE(RESET_MODE), .MODE_W(MODE_W)
    ) u_fsm (
        .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .mode_valid_i(mode_valid_i),
        .mode_ready_o(mode_ready_o), .mode_o(mode_o), .mode_err_o(mode_err_o),
        .state_o(state), .switch_cnt_o(switch_cnt_o)
    );
    assign active = (state == ACTIVE);
    for (genvar m = 0; m < N_MODES; m++) begin : g_slice
        assign blk_en_o[m]               = active && (int'(mode_o) == m);
        assign blk_in_o[m*IN_W +: IN_W]  = blk_en_o[m] ? mux_i : '0;
    end
    // Zero while draining/applying so old and new mode data never meet on the pads.
    assign mux_d = active ? blk_out_i[mode_o*OUT_W +: OUT_W] : '0;
    always_ff @(posedge clk_i) begin
        if (rst_i) mux_q <= '0;
        else mux_q <= mux_d;
    end
    assign mux_o = mux_q;
endmodule

// File: tb/tb_zigbee_io_router.sv
// tb_zigbee_io_router: scoreboard bench with directed and random mode requests against a cycle-count reference model.
module tb_zigbee_io_router;
    localparam int N = 3, IN_W = 22, OUT_W = 18, G = 4, RM = 0, MW = 2;
    logic clk_i = 1'b0, rst_i = 1'b1, mode_valid_i = 1'b0;
    logic [MW-1:0] mode_i = '0, mode_o;
    logic mode_ready_o, mode_err_o;
    logic [IN_W-1:0] mux_i = '0;
    logic [OUT_W-1:0] mux_o;
    logic [N*IN_W-1:0] blk_in_o;
    logic [N*OUT_W-1:0] blk_out_i = '0;
    logic [N-1:0] blk_en_o;
    logic [15:0] switch_cnt_o;

    zigbee_io_router #(.N_MODES(N), .IN_W(IN_W), .OUT_W(OUT_W), .GUARD_CYCLES(G), .RESET_MODE(RM)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .mode_valid_i(mode_valid_i),
        .mode_ready_o(mode_ready_o), .mode_o(mode_o), .mode_err_o(mode_err_o),
        .mux_i(mux_i), .mux_o(mux_o), .blk_in_o(blk_in_o), .blk_out_i(blk_out_i),
        .blk_en_o(blk_en_o), .switch_cnt_o(switch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [MW-1:0] mode;
        logic ready, err;
        logic [N-1:0] en;
        logic [OUT_W-1:0] mux;
        logic [N*IN_W-1:0] bin;
        logic [15:0] cnt;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;

    // Reference model: m_rem counts the cycles left until the requested mode is live (0 = routing).
    int m_mode, m_rem, m_pend, m_cnt;
    bit m_err, known = 0;
    logic [OUT_W-1:0] m_mux;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [IN_W-1:0] rnd_in();
        return IN_W'($urandom);
    endfunction
    function automatic logic [N*OUT_W-1:0] rnd_bo();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[N*OUT_W-1:0];
    endfunction

    task automatic push_exp();
        exp_t e;
        logic [N*IN_W-1:0] b;
        b = '0;
        b[IN_W-1:0] = mux_i;
        e.mode  = MW'(m_mode);
        e.ready = (m_rem == 0);
        e.err   = m_err;
        e.en    = (m_rem == 0) ? N'(1 << m_mode) : '0;
        e.bin   = (m_rem == 0) ? (b << (m_mode * IN_W)) : '0;
        e.mux   = m_mux;
`ifdef ZIGBEE_IO_ROUTER_SWITCH_CNT_EN
        e.cnt   = 16'(m_cnt);
`else
        e.cnt   = 16'h0;
`endif
        q.push_back(e);
    endtask

    task automatic model_edge();
        logic [N*OUT_W-1:0] t;
        if (rst_i) begin
            m_mode = RM; m_rem = 0; m_err = 0; m_cnt = 0; m_mux = '0; m_pend = RM; known = 1;
        end else if (known) begin
            t = blk_out_i >> (m_mode * OUT_W);
            m_mux = (m_rem == 0) ? t[OUT_W-1:0] : '0;
            if (m_rem == 0) begin
                if (mode_valid_i && int'(mode_i) >= N) m_err = 1;
                else if (mode_valid_i && int'(mode_i) != m_mode) begin
                    m_pend = int'(mode_i);
                    m_rem  = G + 1;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_mode = m_pend;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [MW-1:0] m,
                         input logic [IN_W-1:0] mi, input logic [N*OUT_W-1:0] bo);
        rst_i = r; mode_valid_i = v; mode_i = m; mux_i = mi; blk_out_i = bo;
        if (known) push_exp();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, MW'($urandom_range(0, 3)), rnd_in(), rnd_bo());
    endtask

    task automatic req(input int m);
        drive(1'b0, 1'b1, MW'(m), rnd_in(), rnd_bo());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mode_o", mode_o, e.mode);
                chk("mode_ready_o", mode_ready_o, e.ready);
                chk("mode_err_o", mode_err_o, e.err);
                chk("blk_en_o", blk_en_o, e.en);
                chk("blk_in_o", blk_in_o, e.bin);
                chk("mux_o", mux_o, e.mux);
                chk("switch_cnt_o", switch_cnt_o, e.cnt);
            end
        end
    end

    initial begin : stim
        logic [N*OUT_W-1:0] bo0;
        bo0 = rnd_bo();
        bo0[OUT_W-1:0] = 18'h2A5A5;
        drive(1'b1, 1'b0, '0, rnd_in(), bo0);
        drive(1'b1, 1'b0, '0, rnd_in(), bo0);
        drive(1'b0, 1'b0, '0, rnd_in(), bo0);
        drive(1'b0, 1'b0, '0, rnd_in(), bo0);
        idle(2);
        req(2); idle(8);
        req(3); idle(2);
        req(1); idle(8);
        req(1); idle(2);
        req(0); req(1); idle(8);
        req(2); idle(1);
        drive(1'b1, 1'b0, '0, rnd_in(), rnd_bo());
        idle(3);
        for (int i = 0; i < 400; i++)
            drive(1'b0 || ($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
                  MW'($urandom_range(0, 3)), rnd_in(), rnd_bo());
        idle(2);
        @(negedge clk_i);
        #1;
        chk("scoreboard_drained", 128'(q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
